morse_symbol_player: RTL and testbench

//  Sequences the unit-tick timer (100 ms-class "Countto" counter) to play one Morse character on an LED.

---
 rtl/morse_pkg.sv | 25 ++
 rtl/morse_unit_counter.sv | 30 +++
 rtl/morse_symbol_player.sv | 138 +++++++++++++
 tb/tb_morse_symbol_player.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and defaults for the Morse symbol player.
// Optional abort support is enabled with the MORSE_ABORT_EN macro (see morse_symbol_player).
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_IGAP,
    ST_CGAP,
    ST_DONE
  } state_e;

  localparam logic ELEM_DOT  = 1'b0;
  localparam logic ELEM_DASH = 1'b1;

  localparam int MAX_LEN_DEF    = 5;
  localparam int DASH_UNITS_DEF = 3;
  localparam int IGAP_UNITS_DEF = 1;
  localparam int CGAP_UNITS_DEF = 3;

  function automatic logic [2:0] clamp_len(input logic [2:0] len, input int max_len);
    return (int'(len) > max_len) ? 3'(max_len) : len;
  endfunction

endpackage

// File: rtl/morse_unit_counter.sv
// Counts unit ticks while enabled and flags the tick that completes the current phase.
// Held at zero whenever disabled, so each phase starts from a clean count.
module morse_unit_counter (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  input  logic       tick_i,
  input  logic [1:0] last_i,
  output logic       expire_o
);

  logic [1:0] cnt_q, cnt_d;

  assign expire_o = en_i & tick_i & (cnt_q == last_i);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || expire_o) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/morse_symbol_player.sv
// Plays one Morse character (length + dot/dash bits) on an LED, timed in whole timer units.
// Define MORSE_ABORT_EN to add the abort input and the aborted qualifier on done.
module morse_symbol_player
  import morse_pkg::*;
#(
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int DASH_UNITS = DASH_UNITS_DEF,
  parameter int IGAP_UNITS = IGAP_UNITS_DEF,
  parameter int CGAP_UNITS = CGAP_UNITS_DEF
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [2:0]         sym_len_i,
  input  logic [MAX_LEN-1:0] sym_bits_i,
  input  logic               tick_i,
`ifdef MORSE_ABORT_EN
  input  logic               abort_i,
  output logic               aborted_o,
`endif
  output logic               tmr_en_o,
  output logic               led_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [2:0]         elem_idx_o
);

  state_e             state_q, state_d;
  logic [2:0]         len_q, len_d;
  logic [MAX_LEN-1:0] bits_q, bits_d;
  logic [2:0]         idx_q, idx_d;
  logic [1:0]         last_unit;
  logic               expire;
  logic               timing;
  logic [2:0]         len_in;

  assign timing = (state_q == ST_MARK) || (state_q == ST_IGAP) || (state_q == ST_CGAP);
  assign len_in = clamp_len(sym_len_i, MAX_LEN);

  // Counter compare value is the index of the final unit of the current phase.
  always_comb begin
    last_unit = 2'd0;
    case (state_q)
      ST_MARK: last_unit = (bits_q[idx_q] == ELEM_DOT) ? 2'd0 : 2'(DASH_UNITS - 1);
      ST_IGAP: last_unit = 2'(IGAP_UNITS - 1);
      ST_CGAP: last_unit = 2'(CGAP_UNITS - 1);
      default: last_unit = 2'd0;
    endcase
  end

  morse_unit_counter u_cnt (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .en_i     (timing),
    .tick_i   (tick_i),
    .last_i   (last_unit),
    .expire_o (expire)
  );

`ifdef MORSE_ABORT_EN
  logic aborted_q, aborted_d;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bits_d  = bits_q;
    idx_d   = idx_q;
`ifdef MORSE_ABORT_EN
    aborted_d = aborted_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d   = len_in;
          bits_d  = sym_bits_i;
          idx_d   = '0;
          state_d = (len_in == 3'd0) ? ST_DONE : ST_MARK;
`ifdef MORSE_ABORT_EN
          aborted_d = 1'b0;
`endif
        end
      end
      ST_MARK: begin
        if (expire) state_d = (idx_q == 3'(len_q - 3'd1)) ? ST_CGAP : ST_IGAP;
      end
      ST_IGAP: begin
        if (expire) begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_MARK;
        end
      end
      ST_CGAP: begin
        if (expire) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef MORSE_ABORT_EN
    // Abort overrides any tick-driven transition in the same cycle.
    if (abort_i && timing) begin
      state_d   = ST_DONE;
      idx_d     = idx_q;
      aborted_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      bits_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bits_q  <= bits_d;
      idx_q   <= idx_d;
    end
  end

`ifdef MORSE_ABORT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) aborted_q <= 1'b0;
    else          aborted_q <= aborted_d;
  end

  assign aborted_o = (state_q == ST_DONE) & aborted_q;
`endif

  assign tmr_en_o   = timing;
  assign led_o      = (state_q == ST_MARK);
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);
  assign elem_idx_o = idx_q;

endmodule

// File: tb/tb_morse_symbol_player.sv
// Self-checking bench for morse_symbol_player: directed characters plus random ones
// compared unit-by-unit against a waveform model built from the Morse timing rules.
module tb_morse_symbol_player;

  localparam int MAX_LEN = 5;
  localparam int DASH_U  = 3;
  localparam int IGAP_U  = 1;
  localparam int CGAP_U  = 3;

  typedef struct {
    logic       led;
    logic [2:0] idx;
  } unit_t;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [2:0]         sym_len;
  logic [MAX_LEN-1:0] sym_bits;
  logic               tick;
  logic               tmr_en;
  logic               led;
  logic               busy;
  logic               done;
  logic [2:0]         elem_idx;
`ifdef MORSE_ABORT_EN
  logic               abort;
  logic               aborted;
`endif

  int checks   = 0;
  int failures = 0;

  morse_symbol_player dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .sym_len_i  (sym_len),
    .sym_bits_i (sym_bits),
    .tick_i     (tick),
`ifdef MORSE_ABORT_EN
    .abort_i    (abort),
    .aborted_o  (aborted),
`endif
    .tmr_en_o   (tmr_en),
    .led_o      (led),
    .busy_o     (busy),
    .done_o     (done),
    .elem_idx_o (elem_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit timer stand-in: one tick every 4 clk while enabled, cleared when disabled.
  initial begin
    int div;
    div  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tmr_en === 1'b1) begin
        div++;
        if (div == 4) begin
          tick = 1'b1;
          div  = 0;
        end else begin
          tick = 1'b0;
        end
      end else begin
        div  = 0;
        tick = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected per-unit waveform: marks then a one-unit gap between elements, long gap at the end.
  task automatic build_model(input logic [2:0] len, input logic [MAX_LEN-1:0] bits,
                             output unit_t q[$]);
    int n;
    unit_t u;
    q = {};
    n = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
    for (int e = 0; e < n; e++) begin
      for (int i = 0; i < (bits[e] ? DASH_U : 1); i++) begin
        u.led = 1'b1; u.idx = 3'(e); q.push_back(u);
      end
      for (int i = 0; i < ((e == n - 1) ? CGAP_U : IGAP_U); i++) begin
        u.led = 1'b0; u.idx = 3'(e); q.push_back(u);
      end
    end
  endtask

  task automatic play(input logic [2:0] len, input logic [MAX_LEN-1:0] bits,
                      input bit mid_start, input string tag, output int nticks);
    unit_t q[$];
    int k, cyc, since;
    bit got_done, injected, inj_active;
    build_model(len, bits, q);
    @(negedge clk); #1;
    start = 1'b1; sym_len = len; sym_bits = bits;
    @(negedge clk); #1;
    start = 1'b0; sym_len = 3'($urandom); sym_bits = MAX_LEN'($urandom);
    check({tag, "_busy_rise"}, int'(busy), 1);
    if (q.size() > 0) check({tag, "_led_rise"}, int'(led), 1);
    k = 0; cyc = 0; since = 99; got_done = 0; injected = 0; inj_active = 0;
    while (!got_done && cyc < 2000) begin
      if (inj_active) begin
        start = 1'b0; inj_active = 0;
      end
      if (done === 1'b1) begin
        got_done = 1;
        if (q.size() > 0) check({tag, "_done_lat"}, since, 1);
        check({tag, "_done_led"}, int'(led), 0);
      end else begin
        if (tick === 1'b1) begin
          if (k < q.size()) begin
            check({tag, "_led_unit"}, int'(led), int'(q[k].led));
            check({tag, "_idx_unit"}, int'(elem_idx), int'(q[k].idx));
          end
          k++;
          since = 0;
        end
        if (mid_start && !injected && k == 3) begin
          start = 1'b1; sym_len = 3'd1; sym_bits = '1;
          injected = 1; inj_active = 1;
        end
        @(negedge clk); #1;
        since++;
        cyc++;
      end
    end
    if (!got_done) check({tag, "_timeout"}, 0, 1);
    check({tag, "_ticks"}, k, q.size());
    nticks = k;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check({tag, "_post_busy"}, int'(busy), 0);
      check({tag, "_post_done"}, int'(done), 0);
    end
  endtask

  initial begin
    int n, k, cyc;
    logic [2:0] rl;
    logic [MAX_LEN-1:0] rb;
    rst_n = 1'b0; start = 1'b0; sym_len = '0; sym_bits = '0;
`ifdef MORSE_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_tmr_en", int'(tmr_en), 0);
    check("rst_idx", int'(elem_idx), 0);
    rst_n = 1'b1;

    play(3'd2, 5'b00010, 0, "A", n);
    check("A_total", n, 8);
    play(3'd1, 5'b00000, 0, "E", n);
    check("E_total", n, 4);
    play(3'd0, 5'b10101, 0, "len0", n);
    check("len0_total", n, 0);
    play(3'd7, 5'b11111, 0, "len7", n);
    check("len7_total", n, 22);
    play(3'd2, 5'b00010, 1, "A_mid", n);
    check("A_mid_total", n, 8);

    // Reset during the dash of 'A'.
    @(negedge clk); #1;
    start = 1'b1; sym_len = 3'd2; sym_bits = 5'b00010;
    @(negedge clk); #1;
    start = 1'b0;
    k = 0; cyc = 0;
    while (k < 3 && cyc < 200) begin
      if (tick === 1'b1) k++;
      @(negedge clk); #1;
      cyc++;
    end
    check("mrst_reach", k, 3);
    check("mrst_in_mark", int'(led), 1);
    rst_n = 1'b0;
    #1;
    check("mrst_led", int'(led), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_tmr_en", int'(tmr_en), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("mrst_no_done", int'(done), 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("mrst_idle", int'(busy), 0);
    end
    play(3'd2, 5'b00010, 0, "A_after_rst", n);
    check("A_after_rst_total", n, 8);

`ifdef MORSE_ABORT_EN
    @(negedge clk); #1;
    start = 1'b1; sym_len = 3'd2; sym_bits = 5'b00010;
    @(negedge clk); #1;
    start = 1'b0;
    k = 0; cyc = 0;
    while (k < 1 && cyc < 200) begin
      if (tick === 1'b1) k++;
      @(negedge clk); #1;
      cyc++;
    end
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    check("abort_done", int'(done), 1);
    check("abort_flag", int'(aborted), 1);
    check("abort_led", int'(led), 0);
    @(negedge clk); #1;
    check("abort_busy", int'(busy), 0);
`endif

    for (int r = 0; r < 8; r++) begin
      rl = 3'($urandom_range(0, 7));
      rb = MAX_LEN'($urandom);
      play(rl, rb, bit'($urandom_range(0, 1)), "rand", n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
